cmd_cfg: RTL

//  Command responder inside LA_dig; the far end of the host CommMaster link. Takes 16-bit commands

---
 rtl/cmd_cfg_if.sv | 33 +++
 rtl/cmd_cfg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : cmd_cfg_if
// Description : Command/response handshake between the UART wrapper and cmd_cfg.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmd_cfg_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        output cmd,
        output cmd_rdy,
        output resp_sent,
        input  clr_cmd_rdy,
        input  resp,
        input  send_resp
    );

    modport slave (
        input  cmd,
        input  cmd_rdy,
        input  resp_sent,
        output clr_cmd_rdy,
        output resp,
        output send_resp
    );
endinterface
`default_nettype wire

// File: rtl/cmd_cfg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_cfg
// Description : Host command responder: register read/write, channel dump,
//               and owner of the configuration register file (cfg_bus).
//               Optional feature macro: CMD_CFG_DUMP_CHKSUM_EN appends an XOR
//               checksum byte after every dump stream.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_cfg #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    cmd_cfg_if.slave        host,
    input  logic            set_capture_done,
    input  logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] raddr,
    input  logic [39:0]     rdata,
    output logic [135:0]    cfg_bus
);

    localparam logic [1:0]      c_OP_RD    = 2'b00;
    localparam logic [1:0]      c_OP_WR    = 2'b01;
    localparam logic [1:0]      c_OP_DUMP  = 2'b10;
    localparam logic [7:0]      c_ACK      = 8'hA5;
    localparam logic [7:0]      c_NAK      = 8'hEE;
    localparam logic [5:0]      c_MAX_ADDR = 6'h10;
    localparam logic [LOG2-1:0] c_LAST     = LOG2'(ENTRIES - 1);

    // Register n occupies byte n, register 0x10 is the top byte.
    localparam logic [135:0] c_DEFAULTS = {
        8'h01, 8'h00, 8'hC8, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55,
        8'hAA, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h03
    };

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SENT = 3'd1,
        ST_DUMP_RD   = 3'd2,
        ST_DUMP_TX   = 3'd3,
        ST_DUMP_WAIT = 3'd4
`ifdef CMD_CFG_DUMP_CHKSUM_EN
        , ST_DUMP_CHK = 3'd5
`endif
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_clr, w_clr_nxt;
    logic            r_send, w_send_nxt;
    logic [7:0]      r_resp, w_resp_nxt;
    logic [LOG2-1:0] r_raddr, w_raddr_nxt;
    logic [LOG2-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_chan, w_chan_nxt;
    logic [135:0]    r_cfg;
`ifdef CMD_CFG_DUMP_CHKSUM_EN
    logic [7:0]      r_chk, w_chk_nxt;
`endif

    logic [1:0] w_op;
    logic [5:0] w_addr;
    logic [7:0] w_data;
    logic [2:0] w_ch;
    logic       w_addr_ok;
    logic       w_ch_ok;
    logic [7:0] w_rd_val;
    logic [7:0] w_dump_byte;
    logic       w_we;
    logic [7:0] w_wdata;

    assign w_op      = host.cmd[15:14];
    assign w_addr    = host.cmd[13:8];
    assign w_data    = host.cmd[7:0];
    assign w_ch      = host.cmd[10:8];
    assign w_addr_ok = (w_addr <= c_MAX_ADDR);
    assign w_ch_ok   = (w_ch != 3'd0) && (w_ch <= 3'd5);
    assign w_rd_val  = r_cfg[{w_addr[4:0], 3'b000} +: 8];
    // TrigCfg[7:6] are hard zero so the host cannot set them.
    assign w_wdata   = (w_addr == 6'h00) ? {2'b00, w_data[5:0]} : w_data;

    always_comb begin
        w_dump_byte = 8'h00;
        case (r_chan)
            3'd1:    w_dump_byte = rdata[7:0];
            3'd2:    w_dump_byte = rdata[15:8];
            3'd3:    w_dump_byte = rdata[23:16];
            3'd4:    w_dump_byte = rdata[31:24];
            3'd5:    w_dump_byte = rdata[39:32];
            default: w_dump_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        w_send_nxt  = 1'b0;
        w_resp_nxt  = r_resp;
        w_raddr_nxt = r_raddr;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_we        = 1'b0;
`ifdef CMD_CFG_DUMP_CHKSUM_EN
        w_chk_nxt   = r_chk;
`endif
        case (r_state)
            ST_IDLE: begin
                if (host.cmd_rdy) begin
                    w_clr_nxt   = 1'b1;
                    w_send_nxt  = 1'b1;
                    w_resp_nxt  = c_NAK;
                    w_state_nxt = ST_WAIT_SENT;
                    case (w_op)
                        c_OP_RD: begin
                            if (w_addr_ok) w_resp_nxt = w_rd_val;
                        end
                        c_OP_WR: begin
                            if (w_addr_ok) begin
                                w_we       = 1'b1;
                                w_resp_nxt = c_ACK;
                            end
                        end
                        c_OP_DUMP: begin
                            // A valid dump streams data only; there is no ACK byte.
                            if (w_ch_ok) begin
                                w_send_nxt  = 1'b0;
                                w_resp_nxt  = r_resp;
                                w_chan_nxt  = w_ch;
                                w_raddr_nxt = waddr;
                                w_cnt_nxt   = '0;
                                w_state_nxt = ST_DUMP_RD;
`ifdef CMD_CFG_DUMP_CHKSUM_EN
                                w_chk_nxt   = 8'h00;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_SENT: begin
                if (host.resp_sent) w_state_nxt = ST_IDLE;
            end
            ST_DUMP_RD: begin
                w_state_nxt = ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
                w_send_nxt  = 1'b1;
                w_resp_nxt  = w_dump_byte;
                w_state_nxt = ST_DUMP_WAIT;
`ifdef CMD_CFG_DUMP_CHKSUM_EN
                w_chk_nxt   = r_chk ^ w_dump_byte;
`endif
            end
            ST_DUMP_WAIT: begin
                if (host.resp_sent) begin
                    if (r_cnt == c_LAST) begin
`ifdef CMD_CFG_DUMP_CHKSUM_EN
                        w_state_nxt = ST_DUMP_CHK;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_raddr_nxt = (r_raddr == c_LAST) ? '0 : r_raddr + 1'b1;
                        w_state_nxt = ST_DUMP_RD;
                    end
                end
            end
`ifdef CMD_CFG_DUMP_CHKSUM_EN
            ST_DUMP_CHK: begin
                w_send_nxt  = 1'b1;
                w_resp_nxt  = r_chk;
                w_state_nxt = ST_WAIT_SENT;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_clr   <= 1'b0;
            r_send  <= 1'b0;
            r_resp  <= 8'h00;
            r_raddr <= '0;
            r_cnt   <= '0;
            r_chan  <= 3'd0;
`ifdef CMD_CFG_DUMP_CHKSUM_EN
            r_chk   <= 8'h00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_clr   <= w_clr_nxt;
            r_send  <= w_send_nxt;
            r_resp  <= w_resp_nxt;
            r_raddr <= w_raddr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
`ifdef CMD_CFG_DUMP_CHKSUM_EN
            r_chk   <= w_chk_nxt;
`endif
        end
    end

    // Capture-done is applied after the host write so that the set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg <= c_DEFAULTS;
        end else begin
            if (w_we) r_cfg[{w_addr[4:0], 3'b000} +: 8] <= w_wdata;
            if (set_capture_done) r_cfg[5] <= 1'b1;
        end
    end

    assign host.clr_cmd_rdy = r_clr;
    assign host.send_resp   = r_send;
    assign host.resp        = r_resp;
    assign raddr            = r_raddr;
    assign cfg_bus          = r_cfg;

endmodule
`default_nettype wire
